rtc_prescaler: RTL and testbench
================================

# rtc_prescaler

Parametrised, runtime-programmable prescaler that turns an asynchronous external oscillator input into a calibrated 1 Hz tick stream for the RTC core. It replaces the fixed divider stage: it adds a programmable divide ratio, periodic signed trim for crystal calibration, a loss-of-signal detector, an enable and a free-running seconds count. It sits between the oscillator pin and the timekeeping counters, in the single system clock domain.

## Interface
- PRE_WIDTH, 7: prescaler width; one pre-tick per 2^PRE_WIDTH trig edges.
- DIV_WIDTH, 20: width of the divide register and main counter.
- DEFAULT_DIV, 78125: reset value of the divide register; 10 MHz / 128 / 78125 = 1 Hz.
- TRIM_WIDTH, 8: width of the signed trim value, two's complement.
- CAL_WIDTH, 5: trim applies to one second in every 2^CAL_WIDTH seconds.
- LOS_CYCLES, 1000: clk cycles without a trig edge before los asserts.
- SEC_WIDTH, 32: width of the seconds counter.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  external oscillator, asynchronous to clk.
- enable  in  1  high = run; low = freeze.
- div_value  in  DIV_WIDTH  new divide ratio, in pre-ticks per second.
- trim_value  in  TRIM_WIDTH  new signed trim, in pre-ticks.
- div_load  in  1  single-cycle strobe that loads div_value and trim_value.
- one_hz  out  1  one-cycle pulse once per second.
- half_hz_50  out  1  toggles on each one_hz, giving 0.5 Hz at 50 % duty.
- sec_count  out  SEC_WIDTH  count of one_hz pulses; wraps.
- los  out  1  loss of signal on trig.

## Operation
- **Synchronizer**
  - trig passes through two flops, s1 then s2, plus a delay flop s2_d.
  - edge = s2 & ~s2_d. This is the only trig-derived event used.
- **Prescaler**
  - PRE_WIDTH-bit up counter that increments on each edge while enable is high.
  - On an edge with the prescaler at all-ones, it wraps to 0 and the registered pre_tick is set high for 1 cycle.
- **Main counter and period**
  - The main counter counts pre_ticks.
  - Period P = div_reg when cal_count != 0.
  - Period P = div_reg + sign-extended trim_reg when cal_count == 0.
  - P is computed at DIV_WIDTH+1 bits signed and clamped to [2, 2^DIV_WIDTH-1].
  - On a pre_tick with counter == P-1: counter <= 0, one_hz <= 1, half_hz_50 toggles, sec_count += 1, cal_count += 1 (modulo 2^CAL_WIDTH).
  - On any other pre_tick: counter += 1.
- **Load (div_load high)**
  - div_reg <= div_value and trim_reg <= trim_value.
  - Prescaler, main counter, cal_count and pre_tick are set to 0.
  - half_hz_50 and sec_count are unchanged.
  - Load is accepted regardless of enable.
- **Enable low**
  - Prescaler, main counter and cal_count hold their values.
  - Edges are ignored, and a pre_tick pending in that cycle is discarded.
  - one_hz = 0; half_hz_50 and sec_count hold.
  - The synchronizer and LOS logic keep running.
- **LOS**
  - Counter of clk cycles since the last edge, saturating at LOS_CYCLES.
  - los = 1 while the counter equals LOS_CYCLES.
  - An edge clears the counter to 0; los deasserts the next cycle.
- **Priority:** rst > div_load > enable-low > normal counting.

## Timing
- **Reset values**
  - one_hz = 0, half_hz_50 = 0, sec_count = 0, los = 0.
  - div_reg = DEFAULT_DIV, trim_reg = 0.
  - All counters, the synchronizer flops and pre_tick = 0.
- **Latency**
  - trig first sampled high at posedge N: s2 = 1 after N+1, edge active in cycle N+1..N+2.
  - The prescaler wraps at N+2, with pre_tick high after N+2.
  - one_hz is high after N+3, and half_hz_50 and sec_count update at the same edge.
- one_hz is exactly 1 cycle wide. Back-to-back pulses are impossible because P >= 2.
- The minimum trig high and low time is 2 clk periods. Shorter pulses may be lost; this is not an error condition.
- **Simultaneous events**
  - div_load in the same cycle as a terminal pre_tick: the load wins, with no one_hz, no toggle and no sec_count increment.
  - Edge in the same cycle as LOS saturation: the counter clears and los stays 0.
- **Wrap-around**
  - sec_count wraps from all-ones to 0 on a pulse.
  - cal_count wraps to 0, and that second uses the trimmed period.
- Reset asserted mid-second: all state returns to its reset value at the next posedge. The first one_hz after release needs a full P·2^PRE_WIDTH edges.

## Test plan
- PRE_WIDTH=2, DEFAULT_DIV=5, trig square wave of 8 clk periods -> one_hz every 20 edges (160 clk); half_hz_50 toggles each pulse; first pulse 3 clk after the 20th edge is sampled.
- Trim test: CAL_WIDTH=2, div 5, trim -2 loaded -> second 0 lasts 3 pre-ticks and seconds 1-3 last 5; sec_count increments 4 times per 18 pre-ticks. Trim -10 clamps to P=2.
- div_load issued on a terminal pre_tick cycle -> no one_hz, counters 0, next pulse after a full new period; half_hz_50 and sec_count unchanged.
- enable low for 50 edges mid-count -> no pulses; the count resumes from the held value and the pulse is delayed by exactly the masked time.
- trig stuck low: los = 1 at LOS_CYCLES (e.g. 10) cycles after the last edge; on the next edge los = 0 one cycle after the edge is detected.
- rst asserted mid-second and sec_count preset near wrap (SEC_WIDTH=4, 15 pulses then one more) -> all outputs 0 after reset; sec_count wraps 15 -> 0.

Source files
------------

// File: rtl/rtc_prescaler_if.sv
// Bus bundle for rtc_prescaler: oscillator input, run control, ratio/trim load
// and the tick outputs toward the RTC core.
interface rtc_prescaler_if #(
  parameter int unsigned DIV_WIDTH  = 20,
  parameter int unsigned TRIM_WIDTH = 8,
  parameter int unsigned SEC_WIDTH  = 32
);

  logic                  trig;
  logic                  enable;
  logic [DIV_WIDTH-1:0]  div_value;
  logic [TRIM_WIDTH-1:0] trim_value;
  logic                  div_load;
  logic                  one_hz;
  logic                  half_hz_50;
  logic [SEC_WIDTH-1:0]  sec_count;
  logic                  los;

  modport master (
    output trig, enable, div_value, trim_value, div_load,
    input  one_hz, half_hz_50, sec_count, los
  );

  modport slave (
    input  trig, enable, div_value, trim_value, div_load,
    output one_hz, half_hz_50, sec_count, los
  );

endinterface

// File: rtl/rtc_prescaler.sv
// Programmable, trimmable prescaler turning an asynchronous oscillator into a
// calibrated 1 Hz tick, with a seconds count and loss-of-signal detection.
module rtc_prescaler #(
  parameter int unsigned PRE_WIDTH   = 7,
  parameter int unsigned DIV_WIDTH   = 20,
  parameter int unsigned DEFAULT_DIV = 78125,
  parameter int unsigned TRIM_WIDTH  = 8,
  parameter int unsigned CAL_WIDTH   = 5,
  parameter int unsigned LOS_CYCLES  = 1000,
  parameter int unsigned SEC_WIDTH   = 32
) (
  input  logic           clk,
  input  logic           rst,
  rtc_prescaler_if.slave bus
);

  // Period sum is kept two bits wider than the operands so that neither a
  // large divide plus positive trim nor a negative result can alias.
  localparam int unsigned SUM_W = ((DIV_WIDTH > TRIM_WIDTH) ? DIV_WIDTH : TRIM_WIDTH) + 2;
  localparam int unsigned LOS_W = $clog2(LOS_CYCLES + 1);

  localparam logic [PRE_WIDTH-1:0]    PRE_MAX = {PRE_WIDTH{1'b1}};
  localparam logic [LOS_W-1:0]        LOS_MAX = LOS_W'(LOS_CYCLES);
  localparam logic signed [SUM_W-1:0] P_MIN   = SUM_W'(2);
  localparam logic signed [SUM_W-1:0] P_MAX   = SUM_W'({DIV_WIDTH{1'b1}});

  logic                  s1_q, s2_q, s2d_q;
  logic                  trig_edge_c;

  logic [PRE_WIDTH-1:0]  pre_q, pre_d;
  logic                  pre_tick_q, pre_tick_d;

  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [TRIM_WIDTH-1:0] trim_q, trim_d;

  logic signed [SUM_W-1:0] div_ext_c, trim_ext_c, sum_c;
  logic [DIV_WIDTH-1:0]  period_c;
  logic                  term_c;

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CAL_WIDTH-1:0]  cal_q, cal_d;
  logic [SEC_WIDTH-1:0]  sec_q, sec_d;
  logic                  half_q, half_d;
  logic                  one_hz_q, one_hz_d;

  logic [LOS_W-1:0]      los_cnt_q, los_cnt_d;
  logic                  los_q, los_d;

  // Two-flop synchronizer plus delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s2d_q <= 1'b0;
    end else begin
      s1_q  <= bus.trig;
      s2_q  <= s1_q;
      s2d_q <= s2_q;
    end
  end

  assign trig_edge_c = s2_q & ~s2d_q;

  // Prescaler: a pre-tick on every wrap of the edge counter.
  always_comb begin
    pre_d      = pre_q;
    pre_tick_d = 1'b0;
    if (bus.div_load) begin
      pre_d = '0;
    end else if (bus.enable && trig_edge_c) begin
      pre_d      = pre_q + PRE_WIDTH'(1);
      pre_tick_d = (pre_q == PRE_MAX);
    end
  end

  // Ratio and trim registers.
  always_comb begin
    div_d  = div_q;
    trim_d = trim_q;
    if (bus.div_load) begin
      div_d  = bus.div_value;
      trim_d = bus.trim_value;
    end
  end

  // Period of the current second: trim applies only when cal_count is zero.
  always_comb begin
    div_ext_c  = {{(SUM_W - DIV_WIDTH){1'b0}}, div_q};
    trim_ext_c = {{(SUM_W - TRIM_WIDTH){trim_q[TRIM_WIDTH-1]}}, trim_q};
    sum_c      = (cal_q == '0) ? (div_ext_c + trim_ext_c) : div_ext_c;
    if (sum_c < P_MIN) begin
      period_c = DIV_WIDTH'(2);
    end else if (sum_c > P_MAX) begin
      period_c = {DIV_WIDTH{1'b1}};
    end else begin
      period_c = sum_c[DIV_WIDTH-1:0];
    end
  end

  assign term_c = (cnt_q == (period_c - DIV_WIDTH'(1)));

  // Main counter, seconds count and output pulses.
  always_comb begin
    cnt_d    = cnt_q;
    cal_d    = cal_q;
    sec_d    = sec_q;
    half_d   = half_q;
    one_hz_d = 1'b0;
    if (bus.div_load) begin
      cnt_d = '0;
      cal_d = '0;
    end else if (bus.enable && pre_tick_q) begin
      if (term_c) begin
        cnt_d    = '0;
        one_hz_d = 1'b1;
        half_d   = ~half_q;
        sec_d    = sec_q + SEC_WIDTH'(1);
        cal_d    = cal_q + CAL_WIDTH'(1);
      end else begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  // Loss-of-signal: saturating count of cycles since the last edge.
  always_comb begin
    los_cnt_d = los_cnt_q;
    if (trig_edge_c) begin
      los_cnt_d = '0;
    end else if (los_cnt_q != LOS_MAX) begin
      los_cnt_d = los_cnt_q + LOS_W'(1);
    end
    los_d = (los_cnt_d == LOS_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q      <= '0;
      pre_tick_q <= 1'b0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV);
      trim_q     <= '0;
      cnt_q      <= '0;
      cal_q      <= '0;
      sec_q      <= '0;
      half_q     <= 1'b0;
      one_hz_q   <= 1'b0;
      los_cnt_q  <= '0;
      los_q      <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      pre_tick_q <= pre_tick_d;
      div_q      <= div_d;
      trim_q     <= trim_d;
      cnt_q      <= cnt_d;
      cal_q      <= cal_d;
      sec_q      <= sec_d;
      half_q     <= half_d;
      one_hz_q   <= one_hz_d;
      los_cnt_q  <= los_cnt_d;
      los_q      <= los_d;
    end
  end

  assign bus.one_hz     = one_hz_q;
  assign bus.half_hz_50 = half_q;
  assign bus.sec_count  = sec_q;
  assign bus.los        = los_q;

endmodule

// File: tb/tb_rtc_prescaler.sv
// Self-checking bench for rtc_prescaler: directed scenarios plus randomized
// traffic compared every cycle against an edge/pre-tick counting model.
module tb_rtc_prescaler;

  localparam int unsigned PRE_W  = 2;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned DEF_D  = 5;
  localparam int unsigned TRIM_W = 8;
  localparam int unsigned CAL_W  = 2;
  localparam int unsigned LOS_N  = 10;
  localparam int unsigned SEC_W  = 4;

  logic clk;
  logic rst;

  rtc_prescaler_if #(.DIV_WIDTH(DIV_W), .TRIM_WIDTH(TRIM_W), .SEC_WIDTH(SEC_W)) bus ();

  rtc_prescaler #(
    .PRE_WIDTH(PRE_W), .DIV_WIDTH(DIV_W), .DEFAULT_DIV(DEF_D), .TRIM_WIDTH(TRIM_W),
    .CAL_WIDTH(CAL_W), .LOS_CYCLES(LOS_N), .SEC_WIDTH(SEC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state (plain counts of edges, pre-ticks and seconds).
  int m_h0 = 0, m_h1 = 0, m_h2 = 0;
  int m_edges = 0, m_pending = 0, m_ticks = 0, m_cal = 0, m_sec = 0;
  int m_half = 0, m_pulse = 0, m_div = DEF_D, m_trim = 0, m_since = 0, m_los = 0;

  // Bench bookkeeping.
  int cyc = 0;
  logic prev_t = 1'b0;
  logic prev_los = 1'b0;
  int los_rise = -1;
  int rise_q[$];
  int pulse_q[$];
  int secv_q[$];
  bit gen_on = 1'b0;
  int gen_fixed = 4;
  int gen_left = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int period_of(input int div, input int trim, input int cal);
    int p;
    p = (cal == 0) ? div + trim : div;
    if (p < 2) p = 2;
    if (p > (1 << DIV_W) - 1) p = (1 << DIV_W) - 1;
    return p;
  endfunction

  // Edge seen at posedge k comes from trig samples k-2 (high) and k-3 (low).
  task automatic model_step(input logic t, input logic r, input logic ld, input logic en,
                            input int dv, input int tv);
    int ev;
    ev = m_h1 & ~m_h2;
    if (r) begin
      m_edges = 0; m_pending = 0; m_ticks = 0; m_cal = 0; m_sec = 0;
      m_half = 0; m_pulse = 0; m_div = DEF_D; m_trim = 0; m_since = 0; m_los = 0;
      m_h0 = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      if (ev != 0) m_since = 0;
      else if (m_since < LOS_N) m_since++;
      m_los = (m_since == LOS_N) ? 1 : 0;
      m_pulse = 0;
      if (ld) begin
        m_div = dv; m_trim = tv;
        m_edges = 0; m_pending = 0; m_ticks = 0; m_cal = 0;
      end else if (!en) begin
        m_pending = 0;
      end else begin
        if (m_pending != 0) begin
          m_ticks++;
          if (m_ticks == period_of(m_div, m_trim, m_cal)) begin
            m_ticks = 0;
            m_pulse = 1;
            m_half  = 1 - m_half;
            m_sec   = (m_sec + 1) % (1 << SEC_W);
            m_cal   = (m_cal + 1) % (1 << CAL_W);
          end
        end
        m_pending = 0;
        if (ev != 0) begin
          m_edges++;
          if (m_edges == (1 << PRE_W)) begin
            m_edges = 0;
            m_pending = 1;
          end
        end
      end
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = int'(t);
    end
  endtask

  // One clock: advance the trig generator, sample inputs, step model, compare.
  task automatic tick();
    logic t, r, ld, en;
    int dv, tv;
    if (gen_on) begin
      if (gen_left <= 1) begin
        bus.trig = ~bus.trig;
        gen_left = (gen_fixed != 0) ? gen_fixed : int'($urandom_range(2, 5));
      end else begin
        gen_left--;
      end
    end
    t = bus.trig; r = rst; ld = bus.div_load; en = bus.enable;
    dv = int'(bus.div_value);
    tv = int'($signed(bus.trim_value));
    @(posedge clk);
    cyc++;
    if (t && !prev_t) rise_q.push_back(cyc);
    prev_t = t;
    model_step(t, r, ld, en, dv, tv);
    #1;
    chk("one_hz", 32'(bus.one_hz), 32'(m_pulse));
    chk("half_hz_50", 32'(bus.half_hz_50), 32'(m_half));
    chk("sec_count", 32'(bus.sec_count), 32'(m_sec));
    chk("los", 32'(bus.los), 32'(m_los));
    if (bus.one_hz === 1'b1) begin
      pulse_q.push_back(cyc);
      secv_q.push_back(int'(bus.sec_count));
    end
    if (bus.los === 1'b1 && !prev_los) los_rise = cyc;
    prev_los = (bus.los === 1'b1);
  endtask

  task automatic do_load(input int dv, input int tv);
    bus.div_value  = DIV_W'(dv);
    bus.trim_value = TRIM_W'(tv);
    bus.div_load   = 1'b1;
    tick();
    bus.div_load   = 1'b0;
  endtask

  task automatic run_until_pulses(input string tag, input int n, input int budget);
    int start, left;
    start = pulse_q.size();
    left  = budget;
    while ((pulse_q.size() - start) < n && left > 0) begin
      tick();
      left--;
    end
    chk({tag, "_done"}, 32'((pulse_q.size() - start) >= n), 32'd1);
  endtask

  initial begin
    int p0, load_cyc, r_last, budget, gap, sv_half, sv_sec;

    rst = 1'b1;
    bus.trig = 1'b0; bus.enable = 1'b1; bus.div_load = 1'b0;
    bus.div_value = '0; bus.trim_value = '0;

    // Reset state.
    repeat (3) tick();
    chk("rst_one_hz", 32'(bus.one_hz), 32'd0);
    chk("rst_half", 32'(bus.half_hz_50), 32'd0);
    chk("rst_sec", 32'(bus.sec_count), 32'd0);
    chk("rst_los", 32'(bus.los), 32'd0);
    rst = 1'b0;

    // Default ratio, 8-clk square wave: a pulse every 20 edges.
    rise_q.delete(); pulse_q.delete();
    gen_on = 1'b1; gen_fixed = 4; gen_left = 1;
    run_until_pulses("default", 3, 1000);
    if (pulse_q.size() >= 3 && rise_q.size() >= 20) begin
      chk("first_pulse_latency", 32'(pulse_q[0]), 32'(rise_q[19] + 3));
      chk("default_gap1", 32'(pulse_q[1] - pulse_q[0]), 32'd160);
      chk("default_gap2", 32'(pulse_q[2] - pulse_q[1]), 32'd160);
    end

    // Trim -2 on every fourth second.
    do_load(5, -2);
    pulse_q.delete();
    run_until_pulses("trim", 6, 2000);
    if (pulse_q.size() >= 6) begin
      for (int i = 1; i < 6; i++)
        chk("trim_gap", 32'(pulse_q[i] - pulse_q[i-1]), 32'(period_of(5, -2, i % 4) * 32));
      chk("trim_18_preticks", 32'(pulse_q[4] - pulse_q[0]), 32'(18 * 32));
    end

    // Trim -10 clamps the trimmed second to two pre-ticks.
    do_load(5, -10);
    pulse_q.delete();
    run_until_pulses("clamp", 5, 2000);
    if (pulse_q.size() >= 5) begin
      for (int i = 1; i < 5; i++)
        chk("clamp_gap", 32'(pulse_q[i] - pulse_q[i-1]), 32'(period_of(5, -10, i % 4) * 32));
      chk("clamp_min_gap", 32'(pulse_q[4] - pulse_q[3]), 32'd64);
    end

    // Load coinciding with a terminal pre-tick.
    do_load(5, 0);
    run_until_pulses("pre_term", 1, 400);
    budget = 400;
    while (!(m_pending == 1 && m_ticks + 1 == period_of(m_div, m_trim, m_cal)) && budget > 0) begin
      tick();
      budget--;
    end
    chk("term_found", 32'(budget > 0), 32'd1);
    sv_half = int'(bus.half_hz_50);
    sv_sec  = int'(bus.sec_count);
    do_load(5, 0);
    load_cyc = cyc;
    chk("load_term_one_hz", 32'(bus.one_hz), 32'd0);
    chk("load_term_half", 32'(bus.half_hz_50), 32'(sv_half));
    chk("load_term_sec", 32'(bus.sec_count), 32'(sv_sec));
    pulse_q.delete();
    run_until_pulses("after_load", 1, 400);
    if (pulse_q.size() >= 1) begin
      gap = pulse_q[0] - load_cyc;
      chk("after_load_full_period", 32'(gap > 153 && gap <= 161), 32'd1);
    end

    // Enable low for 50 edges delays the next pulse by exactly 400 clk.
    pulse_q.delete();
    run_until_pulses("pre_mask", 1, 400);
    p0 = (pulse_q.size() > 0) ? pulse_q[$] : cyc;
    repeat (40) tick();
    budget = 20;
    while (m_pending != 0 && budget > 0) begin
      tick();
      budget--;
    end
    bus.enable = 1'b0;
    pulse_q.delete();
    repeat (400) tick();
    chk("masked_pulses", 32'(pulse_q.size()), 32'd0);
    bus.enable = 1'b1;
    run_until_pulses("post_mask", 1, 400);
    if (pulse_q.size() >= 1)
      chk("masked_delay", 32'(pulse_q[0] - p0), 32'd560);

    // Trig stuck low: los at LOS cycles after the last edge, clears after next.
    gen_on = 1'b0;
    bus.trig = 1'b0;
    r_last = (rise_q.size() > 0) ? rise_q[$] : cyc;
    los_rise = -1;
    repeat (20) tick();
    chk("los_stuck", 32'(bus.los), 32'd1);
    chk("los_rise_time", 32'(los_rise), 32'(r_last + 2 + LOS_N));
    bus.trig = 1'b1;
    tick();
    tick();
    chk("los_before_edge", 32'(bus.los), 32'd1);
    tick();
    chk("los_after_edge", 32'(bus.los), 32'd0);
    gen_on = 1'b1; gen_fixed = 4; gen_left = 2;

    // Randomized traffic: jittered oscillator, enable toggles, random loads.
    gen_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) bus.enable = ~bus.enable;
      if ($urandom_range(0, 199) == 0)
        do_load(int'($urandom_range(0, 6)), int'($urandom_range(0, 8)) - 4);
      else
        tick();
    end
    bus.enable = 1'b1;
    gen_fixed = 4;

    // Reset mid-second, then run the seconds count through its wrap.
    do_load(5, 0);
    repeat (70) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_one_hz", 32'(bus.one_hz), 32'd0);
    chk("midrst_half", 32'(bus.half_hz_50), 32'd0);
    chk("midrst_sec", 32'(bus.sec_count), 32'd0);
    chk("midrst_los", 32'(bus.los), 32'd0);
    do_load(2, 0);
    secv_q.delete();
    run_until_pulses("wrap", 16, 3000);
    if (secv_q.size() >= 16) begin
      chk("sec_before_wrap", 32'(secv_q[14]), 32'd15);
      chk("sec_wrapped", 32'(secv_q[15]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
